data_cache_nway: RTL and testbench
==================================

DATA_CACHE_NWAY -- requirements
Module: data_cache_nway

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter NUM_WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-004 SHALL have parameters NUM_SETS (default 64) and WORDS_PER_LINE (default 4), each a power of two >= 2.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_i  input  1  CPU access request, held with addr_i/we_i/wdata_i stable until ready_o.
REQ-008 SHALL have ports we_i (input, 1), addr_i (input, ADDR_WIDTH) and wdata_i (input, DATA_WIDTH): write select, byte address with [1:0] ignored, and store data.
REQ-009 SHALL have port flush_i  input  1  single-cycle request to invalidate all lines.
REQ-010 SHALL have ports rdata_o (output, DATA_WIDTH) and ready_o (output, 1): load data, and a one-cycle completion strobe for the current req_i.
REQ-011 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-012 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_WIDTH) and mem_wdata_o (output, DATA_WIDTH) forming the memory word request.
REQ-013 SHALL have ports mem_ack_i (input, 1) and mem_rdata_i (input, DATA_WIDTH): memory acceptance, with read data valid in the ack cycle.
REQ-014 SHALL have ports hit_cnt_o and miss_cnt_o, each output, 32: saturating read-hit and read-miss counters.

Function
REQ-015 SHALL decompose addr_i as word offset [2+OB-1:2] (OB = log2 WORDS_PER_LINE), set index next log2 NUM_SETS bits, and tag as the remaining upper bits.
REQ-016 SHALL keep per way and set a valid bit, a tag and WORDS_PER_LINE data words, plus a per-set round-robin pointer of log2 NUM_WAYS bits.
REQ-017 SHALL implement states IDLE, REFILL, WRITE, RESP and FLUSH.
REQ-018 SHALL, in IDLE, give flush_i priority over req_i and enter FLUSH; a req_i pending during flush is served afterwards.
REQ-019 SHALL, in IDLE on a read hit, drive rdata_o with the hit word and pulse ready_o in the same cycle, increment hit_cnt_o, and make no memory request.
REQ-020 SHALL, in IDLE on a read miss, latch the address, select a victim (lowest-index invalid way, else the set's pointer), increment miss_cnt_o, and enter REFILL.
REQ-021 SHALL, in REFILL, issue WORDS_PER_LINE reads at line base + 4*k for k = 0 up to the last word, holding mem_req_o and mem_addr_o stable until mem_ack_i and writing each acked word into the victim line.
REQ-022 SHALL, on the last refill ack, set valid and tag, set the pointer to (victim + 1) mod NUM_WAYS, and enter RESP.
REQ-023 SHALL, in RESP, drive the requested word on rdata_o, pulse ready_o, and return to IDLE.
REQ-024 SHALL, for a write in IDLE, latch hit/way and enter WRITE (write-through, no-write-allocate); WRITE drives mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i, mem_wdata_o=wdata_i until ack.
REQ-025 SHALL, on the WRITE ack, update the cached word if the access was a hit, pulse ready_o, and return to IDLE; a write miss leaves the cache unchanged.
REQ-026 SHALL, in FLUSH, clear valid for one set per cycle using a set counter, taking exactly NUM_SETS cycles, and clear all pointers.
REQ-027 SHALL ignore flush_i outside IDLE, and SHALL hold mem_req_o=0 in IDLE, RESP and FLUSH.
REQ-028 SHALL hold each counter at 0xFFFFFFFF once reached, and SHALL NOT count writes.
REQ-029 SHALL drive rdata_o to 0 when ready_o is low.

Reset
REQ-030 SHALL, while rst_ni=0, force state IDLE, all valid bits, pointers and counters to 0, and all outputs to 0.
REQ-031 SHALL, on reset asserted mid-REFILL or mid-WRITE, abandon the operation; no partial line becomes valid.

Verification (defaults: 2 ways, 64 sets, 4 words; set = addr[9:4])
REQ-032 SHALL cover: cold read 0x100 with immediate acks returning 0xA0..0xA3 -> mem reads at 0x100/104/108/10C, ready_o after RESP with rdata 0xA0; then read 0x108 -> same-cycle ready_o, rdata 0xA2, hit_cnt=1, miss_cnt=1.
REQ-033 SHALL cover: reads 0x100, 0x500, 0x900 (all set 0x10) -> fills to way0, way1, then way0 evicted; read 0x500 hits and read 0x100 misses.
REQ-034 SHALL cover: write 0x104=0xDEADBEEF after line fill -> mem write with mem_we_o=1, ready_o on ack, later read 0x104 hits with 0xDEADBEEF; write 0x204 then read 0x204 -> miss.
REQ-035 SHALL cover: flush_i after fills -> busy_o high exactly 64 cycles, then read 0x100 misses.
REQ-036 SHALL cover: mem_ack_i delayed 3 cycles per word -> mem_req_o/mem_addr_o held stable; rst_ni low after 2 acks -> mem_req_o=0 immediately, and after release read 0x100 performs a full 4-word refill.

Source files
------------

// File: rtl/data_cache_nway.sv
// N-way set-associative, write-through / no-write-allocate data cache with
// round-robin replacement, word-serial line refill and a set-serial flush.
module data_cache_nway #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
  output logic [2:0]            state_o
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int SB = $clog2(NUM_SETS);
  localparam int TB = ADDR_WIDTH - 2 - OB - SB;
  localparam int WB = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REFILL = 3'd1,
    S_WRITE  = 3'd2,
    S_RESP   = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    valid_q [NUM_WAYS][NUM_SETS];
  logic [TB-1:0]           tag_q   [NUM_WAYS][NUM_SETS];
  logic [DATA_WIDTH-1:0]   data_q  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [WB-1:0]           ptr_q   [NUM_SETS];

  logic [ADDR_WIDTH-1:0]   lat_addr_q;
  logic [WB-1:0]           lat_way_q;
  logic                    lat_hit_q;
  logic [OB-1:0]           word_cnt_q;
  logic [SB-1:0]           flush_cnt_q;

  logic [OB-1:0] req_off, lat_off;
  logic [SB-1:0] req_set, lat_set;
  logic [TB-1:0] req_tag, lat_tag;

  assign req_off = addr_i[2+OB-1:2];
  assign req_set = addr_i[2+OB+SB-1:2+OB];
  assign req_tag = addr_i[ADDR_WIDTH-1:2+OB+SB];
  assign lat_off = lat_addr_q[2+OB-1:2];
  assign lat_set = lat_addr_q[2+OB+SB-1:2+OB];
  assign lat_tag = lat_addr_q[ADDR_WIDTH-1:2+OB+SB];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[1:0], lat_addr_q[1:0]};

  // Lookup: lowest matching way wins; victim is lowest invalid way, else the set's pointer.
  logic          hit, inv_found;
  logic [WB-1:0] hit_way, inv_way, victim;
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[w][req_set] && (tag_q[w][req_set] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!inv_found && !valid_q[w][req_set]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
    victim = inv_found ? inv_way : ptr_q[req_set];
  end

  logic last_word, refill_ack, write_ack;
  logic [WB-1:0] next_ptr;
  assign last_word  = (word_cnt_q == OB'(WORDS_PER_LINE - 1));
  assign refill_ack = (state_q == S_REFILL) && mem_ack_i;
  assign write_ack  = (state_q == S_WRITE) && mem_ack_i;
  assign next_ptr   = (lat_way_q == WB'(NUM_WAYS - 1)) ? '0 : lat_way_q + 1'b1;

  // CPU side: req_i and its operands stay stable until the one-cycle ready_o
  // strobe; the access completes on the rising edge where ready_o is high.
  // Memory side: mem_req_o and its operands stay stable until mem_ack_i; the
  // word transfers on the rising edge where both are high.
  always_comb begin
    ready_o = 1'b0;
    rdata_o = '0;
    case (state_q)
      S_IDLE: if (req_i && !we_i && !flush_i && hit) begin
        ready_o = 1'b1;
        rdata_o = data_q[hit_way][req_set][req_off];
      end
      S_RESP: begin
        ready_o = 1'b1;
        rdata_o = data_q[lat_way_q][lat_set][lat_off];
      end
      S_WRITE: ready_o = mem_ack_i;
      default: ;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == S_REFILL) begin
      mem_req_o  = 1'b1;
      mem_addr_o = {lat_addr_q[ADDR_WIDTH-1:2+OB], word_cnt_q, 2'b00};
    end else if (state_q == S_WRITE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = addr_i;
      mem_wdata_o = wdata_i;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      lat_addr_q  <= '0;
      lat_way_q   <= '0;
      lat_hit_q   <= 1'b0;
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) valid_q[w][s] <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            flush_cnt_q <= '0;
            state_q     <= S_FLUSH;
          end else if (req_i) begin
            lat_addr_q <= addr_i;
            if (we_i) begin
              lat_hit_q <= hit;
              lat_way_q <= hit_way;
              state_q   <= S_WRITE;
            end else if (hit) begin
              if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
              lat_way_q  <= victim;
              word_cnt_q <= '0;
              if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
              state_q    <= S_REFILL;
            end
          end
        end
        S_REFILL: if (mem_ack_i) begin
          word_cnt_q <= word_cnt_q + 1'b1;
          if (last_word) begin
            valid_q[lat_way_q][lat_set] <= 1'b1;
            ptr_q[lat_set]              <= next_ptr;
            state_q                     <= S_RESP;
          end
        end
        S_WRITE: if (mem_ack_i) state_q <= S_IDLE;
        S_RESP:  state_q <= S_IDLE;
        S_FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) valid_q[w][flush_cnt_q] <= 1'b0;
          ptr_q[flush_cnt_q] <= '0;
          flush_cnt_q        <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == SB'(NUM_SETS - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags and data need no reset: a line is only observable once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (refill_ack) begin
      data_q[lat_way_q][lat_set][word_cnt_q] <= mem_rdata_i;
      if (last_word) tag_q[lat_way_q][lat_set] <= lat_tag;
    end
    if (write_ack && lat_hit_q) data_q[lat_way_q][lat_set][lat_off] <= wdata_i;
  end

endmodule

// File: tb/tb_data_cache_nway.sv
// Bench for data_cache_nway: directed scenarios plus randomized traffic, checked
// against a memory model and a tag/replacement reference model.
module tb_data_cache_nway;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NW  = 2;
  localparam int NS  = 64;
  localparam int WPL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, flush = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          ready_o, busy_o, mem_req_o, mem_we_o;
  logic [31:0]   hit_cnt_o, miss_cnt_o;
  logic [2:0]    state_o;

  data_cache_nway #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WAYS(NW), .NUM_SETS(NS), .WORDS_PER_LINE(WPL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .flush_i(flush), .rdata_o(rdata_o), .ready_o(ready_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .state_o(state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- memory model / responder ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_op_t;

  logic [31:0] mem_arr [logic [31:0]];
  mem_op_t     mem_log [$];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] held_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (mem_req_o) begin
        if (wait_cnt == 0) held_addr = mem_addr_o;
        else check_eq("mem_addr_hold", mem_addr_o, held_addr);
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_rd(mem_addr_o);
          if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
          mem_log.push_back('{addr: mem_addr_o, we: mem_we_o, data: mem_wdata_o});
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- reference model: tags, valid, round-robin ----------------
  bit          m_valid [NS][NW];
  int unsigned m_tag   [NS][NW];
  int          m_rr    [NS];
  int unsigned m_hits = 0, m_misses = 0;
  logic [31:0] exp_q [$];

  function automatic int m_set(input logic [31:0] a);
    return int'((a >> 4) & 32'h3F);
  endfunction

  function automatic bit m_is_hit(input logic [31:0] a);
    int s;
    s = m_set(a);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == int'(a >> 10)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s, v;
    s = m_set(a);
    v = -1;
    for (int w = 0; w < NW; w++) if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = m_rr[s];
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = int'(a >> 10);
    m_rr[s]       = (v + 1) % NW;
  endfunction

  function automatic void m_invalidate_all();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [31:0] a, output logic [31:0] rd, output bit hit_obs);
    int          cyc;
    bit          exp_hit;
    logic [31:0] exp_d, e;
    mem_op_t     op;
    exp_hit = m_is_hit(a);
    exp_d   = mem_rd(a);
    mem_log.delete();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #2;
    cyc = 0;
    while (!ready_o && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    rd      = rdata_o;
    hit_obs = (cyc == 0);
    check_eq("rd_ready", ready_o, 1);
    check_eq("rd_hit", 32'(hit_obs), 32'(exp_hit));
    check_eq("rd_data", rd, exp_d);
    @(posedge clk); #1;
    req = 1'b0;
    if (exp_hit) begin
      m_hits++;
      check_eq("hit_no_mem", 32'(mem_log.size()), 0);
    end else begin
      m_misses++;
      m_fill(a);
      for (int k = 0; k < WPL; k++) exp_q.push_back((a & ~32'hF) + 32'(4 * k));
      check_eq("refill_len", 32'(mem_log.size()), WPL);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (mem_log.size() > 0) begin
          op = mem_log.pop_front();
          check_eq("refill_addr", op.addr, e);
          check_eq("refill_we", 32'(op.we), 0);
        end
      end
    end
    check_eq("hit_cnt", hit_cnt_o, m_hits);
    check_eq("miss_cnt", miss_cnt_o, m_misses);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int      cyc;
    mem_op_t op;
    mem_log.delete();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    #2;
    check_eq("wr_not_same_cycle", ready_o, 0);
    cyc = 0;
    while (!ready_o && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    check_eq("wr_ready", ready_o, 1);
    check_eq("wr_mem_ops", 32'(mem_log.size()), 1);
    if (mem_log.size() > 0) begin
      op = mem_log.pop_front();
      check_eq("wr_mem_we", 32'(op.we), 1);
      check_eq("wr_mem_addr", op.addr, a);
      check_eq("wr_mem_data", op.data, d);
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    check_eq("wr_hit_cnt", hit_cnt_o, m_hits);
    check_eq("wr_miss_cnt", miss_cnt_o, m_misses);
  endtask

  task automatic do_flush();
    int cnt;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 200) begin
      check_eq("flush_no_memreq", mem_req_o, 0);
      cnt++;
      @(posedge clk); #1;
    end
    check_eq("flush_busy_cycles", 32'(cnt), NS);
    m_invalidate_all();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bit          h;
    int          cyc;

    m_invalidate_all();
    mem_arr[32'h100] = 32'hA0;
    mem_arr[32'h104] = 32'hA1;
    mem_arr[32'h108] = 32'hA2;
    mem_arr[32'h10C] = 32'hA3;

    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_mem_req", mem_req_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_hit_cnt", hit_cnt_o, 0);
    check_eq("rst_miss_cnt", miss_cnt_o, 0);
    check_eq("rst_state", 32'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // cold miss then hit in the same line
    do_read(32'h100, rd, h);
    check_eq("cold_rdata", rd, 32'hA0);
    check_eq("cold_is_miss", 32'(h), 0);
    do_read(32'h108, rd, h);
    check_eq("warm_rdata", rd, 32'hA2);
    check_eq("warm_is_hit", 32'(h), 1);
    check_eq("warm_hit_cnt", hit_cnt_o, 1);
    check_eq("warm_miss_cnt", miss_cnt_o, 1);

    // three lines into set 0x10: way0, way1, then way0 evicted
    do_read(32'h500, rd, h);
    check_eq("set16_500_miss", 32'(h), 0);
    do_read(32'h900, rd, h);
    check_eq("set16_900_miss", 32'(h), 0);
    do_read(32'h500, rd, h);
    check_eq("set16_500_hit", 32'(h), 1);
    do_read(32'h100, rd, h);
    check_eq("set16_100_evicted", 32'(h), 0);

    // write-through hit updates the line; write miss does not allocate
    do_write(32'h104, 32'hDEAD_BEEF);
    do_read(32'h104, rd, h);
    check_eq("wr_hit_then_read_hit", 32'(h), 1);
    check_eq("wr_hit_data", rd, 32'hDEAD_BEEF);
    do_write(32'h204, 32'h1234_5678);
    do_read(32'h204, rd, h);
    check_eq("wr_miss_no_alloc", 32'(h), 0);
    check_eq("wr_miss_data", rd, 32'h1234_5678);

    // flush invalidates everything
    do_flush();
    do_read(32'h100, rd, h);
    check_eq("post_flush_miss", 32'(h), 0);

    // randomized traffic over 4 sets x 4 tags with varying memory latency
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int          r;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      ack_delay = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 3) do_flush();
      else if (r < 30) do_write(a, $urandom);
      else do_read(a, rd, h);
    end

    // slow memory, reset in the middle of a refill
    ack_delay = 3;
    do_flush();
    mem_log.delete();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h100;
    cyc = 0;
    while (mem_log.size() < 2 && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    check_eq("rst_mid_two_acks", 32'(mem_log.size()), 2);
    @(posedge clk); #1;
    check_eq("rst_mid_req_before", mem_req_o, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req_after", mem_req_o, 0);
    check_eq("rst_mid_busy", busy_o, 0);
    check_eq("rst_mid_ready", ready_o, 0);
    check_eq("rst_mid_miss_cnt", miss_cnt_o, 0);
    req = 1'b0;
    m_invalidate_all();
    m_hits = 0;
    m_misses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h100, rd, h);
    check_eq("rst_refill_miss", 32'(h), 0);
    check_eq("rst_refill_data", rd, 32'hA0);
    do_read(32'h10C, rd, h);
    check_eq("rst_refill_full_line", 32'(h), 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
